// File: rtl/zvc_stream_packer.sv
// zvc_stream_packer: takes one compressed line from the zero-value compressor, finds how many
// leading entries are valid (non-zero MT entry) and streams only those entries out as
// CHUNK_SIZE-entry beats over valid/ready. Beat outputs are registered; the next beat is
// prepared combinationally and loaded on the cycle the previous one is accepted.
module zvc_stream_packer #(
  parameter int unsigned WORD_WIDTH    = 8,
  parameter int unsigned LINE_SIZE     = 128,
  parameter int unsigned DIST_WIDTH    = 7,
  parameter int unsigned MAX_LIFM_RSIZ = 4,
  parameter int unsigned CHUNK_SIZE    = 8,
  localparam int unsigned ME = DIST_WIDTH * MAX_LIFM_RSIZ,
  localparam int unsigned PW = $clog2(LINE_SIZE),
  localparam int unsigned NW = PW + 1,
  localparam int unsigned CW = $clog2(CHUNK_SIZE) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0]  lifm_comp,
  input  logic [LINE_SIZE*ME-1:0]          mt_comp,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHUNK_SIZE*WORD_WIDTH-1:0] out_lifm,
  output logic [CHUNK_SIZE*ME-1:0]         out_mt,
  output logic [CW-1:0]                    out_cnt,
  output logic                             out_last,
  output logic [NW-1:0]                    line_nnz
);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StSend
  } state_e;

  state_e                  state;
  logic [WORD_WIDTH-1:0]   lifm_buf [LINE_SIZE];
  logic [ME-1:0]           mt_buf   [LINE_SIZE];
  logic [NW-1:0]           ptr;

  logic [NW-1:0]                    nnz_c;
  logic [NW-1:0]                    beat_ptr;
  logic [NW-1:0]                    beat_nnz;
  logic [NW-1:0]                    beat_rem;
  logic [NW-1:0]                    slot_idx;
  logic [CHUNK_SIZE*WORD_WIDTH-1:0] beat_lifm;
  logic [CHUNK_SIZE*ME-1:0]         beat_mt;
  logic [CW-1:0]                    beat_cnt;
  logic                             beat_last;

  // Leading-run length = index of the first invalid entry (LINE_SIZE if none is invalid).
  // Scanning downwards lets the lowest invalid index win.
  always_comb begin
    nnz_c = NW'(LINE_SIZE);
    for (int i = LINE_SIZE - 1; i >= 0; i--) begin
      if (mt_buf[i] == '0) begin
        nnz_c = NW'(i);
      end
    end
  end

  // Next beat contents: the first beat while counting, otherwise the beat after ptr.
  always_comb begin
    if (state == StCount) begin
      beat_ptr = '0;
      beat_nnz = nnz_c;
    end else begin
      beat_ptr = ptr + NW'(CHUNK_SIZE);
      beat_nnz = line_nnz;
    end
    beat_rem  = beat_nnz - beat_ptr;
    beat_cnt  = (beat_rem >= NW'(CHUNK_SIZE)) ? CW'(CHUNK_SIZE) : beat_rem[CW-1:0];
    beat_last = (beat_ptr + NW'(CHUNK_SIZE)) >= beat_nnz;
    beat_lifm = '0;
    beat_mt   = '0;
    slot_idx  = '0;
    for (int s = 0; s < CHUNK_SIZE; s++) begin
      slot_idx = beat_ptr + NW'(s);
      // Slots past the valid run stay zero so trailing garbage never leaves the block.
      if (slot_idx < beat_nnz) begin
        beat_lifm[s*WORD_WIDTH +: WORD_WIDTH] = lifm_buf[slot_idx[PW-1:0]];
        beat_mt[s*ME +: ME]                   = mt_buf[slot_idx[PW-1:0]];
      end
    end
  end

  // Control FSM with registered handshake and beat outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_lifm  <= '0;
      out_mt    <= '0;
      out_cnt   <= '0;
      out_last  <= 1'b0;
      line_nnz  <= '0;
      ptr       <= '0;
      for (int i = 0; i < LINE_SIZE; i++) begin
        lifm_buf[i] <= '0;
        mt_buf[i]   <= '0;
      end
    end else begin
      unique case (state)
        StIdle: begin
          if (in_ready && in_valid) begin
            for (int i = 0; i < LINE_SIZE; i++) begin
              lifm_buf[i] <= lifm_comp[i*WORD_WIDTH +: WORD_WIDTH];
              mt_buf[i]   <= mt_comp[i*ME +: ME];
            end
            in_ready <= 1'b0;
            state    <= StCount;
          end else begin
            // First cycle out of reset lands here with in_ready still low.
            in_ready <= 1'b1;
          end
        end
        StCount: begin
          line_nnz  <= nnz_c;
          ptr       <= '0;
          out_valid <= 1'b1;
          out_lifm  <= beat_lifm;
          out_mt    <= beat_mt;
          out_cnt   <= beat_cnt;
          out_last  <= beat_last;
          state     <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_lifm  <= '0;
              out_mt    <= '0;
              out_cnt   <= '0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= StIdle;
            end else begin
              ptr      <= beat_ptr;
              out_lifm <= beat_lifm;
              out_mt   <= beat_mt;
              out_cnt  <= beat_cnt;
              out_last <= beat_last;
            end
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
